ser8_tx: RTL and testbench
==========================

# ser8_tx

Serial transmitter for an 8-bit parallel word. A byte is captured with a single-cycle load strobe and shifted out on one line as a framed sequence: start bit (0), eight data bits LSB first, stop bit (1). It is the sending end of the serial link whose receiving end deserializes frames back into a loadable 8-bit register. It sits between a byte source (register or controller) and the serial pin.

## Interface

Parameters:
- CLKS_PER_BIT, default 4: clock cycles each frame bit is held on tx; legal range 1..255.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- ld  input  1  load strobe; accepted only when busy=0.
- d  input  8  byte to send, sampled on the edge where ld is accepted.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse marking frame completion.

## Operation

- States: IDLE, START, DATA, STOP.
- Reset (rst=1 at a rising edge): state=IDLE, tx=1, busy=0, done=0, bit counter=0, cycle counter=0, shift register=8'h00. Reset overrides ld and aborts any frame in progress; no done pulse for an aborted frame.
- IDLE: tx=1, busy=0. If ld=1: capture d into the shift register, go to START, busy=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift register bit 0; after CLKS_PER_BIT cycles shift right by one and increment the bit index; after bit index 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with busy=0, done=1 for exactly one cycle.
- ld while busy=1 is ignored. Changes to d after capture do not affect the frame.
- ld is accepted in the cycle where done=1, because busy=0 in that cycle. This gives back-to-back frames with exactly one idle-high cycle between the stop bit and the next start bit.
- Cycle counter width: enough bits to hold CLKS_PER_BIT-1. It wraps to 0 at each bit boundary. Bit index is 3 bits.

## Timing

- All outputs are registered and change only after rising edges.
- Edge E0 is the edge where ld=1 and busy=0.
  - After E0: tx=0, busy=1.
  - After E0+CLKS_PER_BIT: tx=d[0].
  - After E0+(k+1)·CLKS_PER_BIT: tx=d[k], for k=0..7.
  - After E0+9·CLKS_PER_BIT: tx=1 (stop bit).
  - After E0+10·CLKS_PER_BIT: busy=0, done=1.
  - After E0+10·CLKS_PER_BIT+1: done=0.
- Frame length is 10·CLKS_PER_BIT cycles. Minimum spacing between accepted loads is 10·CLKS_PER_BIT+1 cycles.
- CLKS_PER_BIT=1: one cycle per bit, same rules apply.
- If rst and ld are both high at the same edge, rst wins: the output is the reset state and nothing is captured.

## Test plan

- Reset: hold rst=1 for 2 edges with ld=1, d=8'hFF -> tx=1, busy=0, done=0; no frame starts after rst drops while ld=0.
- Single frame, CLKS_PER_BIT=4, 20 ns clock: ld pulse with d=8'b10011001 -> tx holds 0,1,0,0,1,1,0,0,1,1, each for 80 ns. busy is high for 800 ns, then done pulses high for 20 ns.
- Ignored load: mid-frame, pulse ld with d=8'h00 -> the frame in progress is unchanged and no second frame follows.
- Back-to-back: assert ld with d=8'h02 in the done cycle -> exactly one idle tx=1 cycle after the stop bit, then start bit; the second frame sends 0,1,0,0,0,0,0,0 as data.
- Reset mid-frame: rst=1 for one edge during data bit 3 -> tx=1, busy=0 next cycle, no done pulse, and a new ld starts a clean frame.
- CLKS_PER_BIT=1 instance: d=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 on 10 consecutive cycles.

Source files
------------

// File: rtl/ser8_tx.sv
// ser8_tx -- framed serial transmitter for one 8-bit word.
//
// A byte loaded with a one-cycle strobe is sent on tx as a start bit (0),
// eight data bits LSB first, and a stop bit (1). Each frame bit is held for
// CLKS_PER_BIT clock cycles. All outputs are registered.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset, aborts any frame in progress
//   ld    in   load strobe, accepted only while busy is low
//   d     in   [7:0] byte to send, sampled on the accepting edge
//   tx    out  serial line, idle high
//   busy  out  high while a frame is in progress
//   done  out  one-cycle pulse after the stop bit completes
module ser8_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] d,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // A counter of at least one bit keeps CLKS_PER_BIT=1 legal; it then stays 0.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (cyc_q == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed for the next state so that tx/busy/done are
  // registered and line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // Also taken in the done cycle, giving back-to-back frames with a
        // single idle-high cycle between them.
        if (ld) begin
          shreg_d = d;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end

      START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shreg_d = {1'b0, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            // Next bit is what becomes bit 0 after this shift.
            tx_d    = shreg_q[1];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ser8_tx.sv
// tb_ser8_tx -- directed bench for ser8_tx, one instance with CLKS_PER_BIT=4
// and one with CLKS_PER_BIT=1, sharing clock and reset.
module tb_ser8_tx;

  logic       clk;
  logic       rst;
  logic       ld4, ld1;
  logic [7:0] d4, d1;
  logic       tx4, busy4, done4;
  logic       tx1, busy1, done1;

  int tests;
  int fails;

  ser8_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld4),
    .d    (d4),
    .tx   (tx4),
    .busy (busy4),
    .done (done4)
  );

  ser8_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld1),
    .d    (d1),
    .tx   (tx1),
    .busy (busy1),
    .done (done1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check the outputs of one instance (sel1=1 selects the CLKS_PER_BIT=1 one).
  task automatic chk_out(input string tag, input bit sel1,
                         input logic etx, input logic ebusy, input logic edone);
    chk({tag, ".tx"},   sel1 ? tx1   : tx4,   etx);
    chk({tag, ".busy"}, sel1 ? busy1 : busy4, ebusy);
    chk({tag, ".done"}, sel1 ? done1 : done4, edone);
  endtask

  // Called at the falling edge right after the accepting edge. seq[0..9] is
  // the hand-written frame bit sequence (start, d0..d7, stop). Ends at the
  // falling edge inside the done cycle, after checking it. ign_at >= 0 pulses
  // ld4 with d4=0 at that cycle of the frame.
  task automatic run_frame(input string tag, input bit sel1,
                           input logic [0:9] seq, input int ign_at);
    int cpb;
    cpb = sel1 ? 1 : 4;
    for (int i = 0; i < 10 * cpb; i++) begin
      chk_out(tag, sel1, seq[i / cpb], 1'b1, 1'b0);
      if (i == ign_at) begin
        ld4 = 1'b1;
        d4  = 8'h00;
      end else begin
        ld4 = 1'b0;
      end
      cyc();
    end
    ld4 = 1'b0;
    chk_out({tag, ".end"}, sel1, 1'b1, 1'b0, 1'b1);
    $display("[TB] frame %s checked, fails so far %0d", tag, fails);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    ld4 = 1'b1; d4 = 8'hFF;
    ld1 = 1'b1; d1 = 8'hFF;

    // Reset held for two edges with ld asserted: nothing captured.
    cyc();
    cyc();
    chk_out("reset4", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("reset1", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    ld4 = 1'b0;
    ld1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_out("idle4", 1'b0, 1'b1, 1'b0, 1'b0);
      chk_out("idle1", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    $display("[TB] reset/idle checked, fails so far %0d", fails);

    // Single frame 0x99, d changed after capture, ignored ld mid-frame.
    ld4 = 1'b1; d4 = 8'b1001_1001;
    cyc();
    ld4 = 1'b0; d4 = 8'h55;
    run_frame("f99", 1'b0, 10'b0100110011, 17);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk_out("after99", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Back-to-back: second load lands in the done cycle.
    ld4 = 1'b1; d4 = 8'h5A;
    cyc();
    ld4 = 1'b0;
    run_frame("f5A", 1'b0, 10'b0010110101, -1);
    ld4 = 1'b1; d4 = 8'h02;
    cyc();
    ld4 = 1'b0;
    run_frame("f02", 1'b0, 10'b0010000001, -1);
    cyc();
    chk_out("after02", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset during data bit 3 aborts the frame without a done pulse.
    ld4 = 1'b1; d4 = 8'hFF;
    cyc();
    ld4 = 1'b0;
    for (int i = 0; i < 17; i++) cyc();
    chk_out("bit3", 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_out("abort", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      cyc();
      chk_out("postabort", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    ld4 = 1'b1; d4 = 8'h3C;
    cyc();
    ld4 = 1'b0;
    run_frame("f3C", 1'b0, 10'b0001111001, -1);

    // One clock per bit.
    ld1 = 1'b1; d1 = 8'hA5;
    cyc();
    ld1 = 1'b0;
    run_frame("fA5", 1'b1, 10'b0101001011, -1);
    cyc();
    chk_out("afterA5", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
